// File: rtl/router_pkg.sv
// Shared router types and default geometry for the switch-allocation input requester.
package router_pkg;

  localparam int unsigned DEF_NUM_VCS      = 4;
  localparam int unsigned DEF_NUM_OUTS     = 3;
  localparam int unsigned DEF_CREDIT_DEPTH = 4;

  // Index width that stays at least one bit for single-entry dimensions.
  function automatic int unsigned width_of(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  localparam int unsigned OUT_W = width_of(DEF_NUM_OUTS);
  localparam int unsigned VC_W  = width_of(DEF_NUM_VCS);
  localparam int unsigned CRD_W = $clog2(DEF_CREDIT_DEPTH + 1);

  typedef enum logic {VC_IDLE, VC_ACTIVE} vc_state_t;

endpackage

// File: rtl/sa_input_requester_credit_counter.sv
// Downstream credit counter for one output port: starts full, saturates on return, never underflows.
module sa_credit_counter
  import router_pkg::*;
#(
  parameter  int unsigned DEPTH = DEF_CREDIT_DEPTH,
  localparam int unsigned W     = $clog2(DEPTH + 1)
) (
  input  logic clk,
  input  logic reset,
  input  logic inc,
  input  logic dec,
  output logic zero,
  output logic overflow
);

  localparam logic [W-1:0] FULL = W'(DEPTH);

  logic [W-1:0] count;

  assign zero     = (count == '0);
  assign overflow = inc & ~dec & (count == FULL);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= FULL;
    end else if (inc & ~dec & ~overflow) begin
      count <= count + 1'b1;
    end else if (dec & ~inc & ~zero) begin
      count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/sa_input_requester.sv
// Switch-allocation requester for one router input port: per-VC packet FSM, credit tracking,
// round-robin VC pick, same-cycle grant/pop and a registered switch-traversal command.
module sa_input_requester
  import router_pkg::*;
#(
  parameter  int unsigned NUM_VCS      = DEF_NUM_VCS,
  parameter  int unsigned NUM_OUTS     = DEF_NUM_OUTS,
  parameter  int unsigned CREDIT_DEPTH = DEF_CREDIT_DEPTH,
  localparam int unsigned OW           = width_of(NUM_OUTS),
  localparam int unsigned VW           = width_of(NUM_VCS)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_VCS-1:0]           vc_valid,
  input  logic [NUM_VCS-1:0]           vc_head,
  input  logic [NUM_VCS-1:0]           vc_tail,
  input  logic [NUM_VCS-1:0][OW-1:0]   vc_outport,
  input  logic [NUM_OUTS-1:0]          credit_return,
  output logic [NUM_OUTS-1:0]          sa_request,
  input  logic [NUM_OUTS-1:0]          sa_grant,
  output logic [NUM_VCS-1:0]           vc_pop,
  output logic                         st_valid,
  output logic [OW-1:0]                st_outport,
  output logic [VW-1:0]                st_vc,
  output logic                         err_protocol
);

  vc_state_t           state      [NUM_VCS];
  vc_state_t           state_next [NUM_VCS];
  logic [OW-1:0]       route_q    [NUM_VCS];
  logic [OW-1:0]       route_next [NUM_VCS];
  logic [OW-1:0]       route      [NUM_VCS];
  logic [NUM_VCS-1:0]  eligible;
  logic [NUM_VCS-1:0]  body_err;
  logic [NUM_OUTS-1:0] crd_zero;
  logic [NUM_OUTS-1:0] crd_dec;
  logic [NUM_OUTS-1:0] crd_ovf;
  logic [VW-1:0]       rr_ptr;
  logic [VW-1:0]       sel;
  logic                found;
  logic                grant;
  logic                stray;

  for (genvar o = 0; o < NUM_OUTS; o++) begin : g_credit
    sa_credit_counter #(.DEPTH(CREDIT_DEPTH)) u_counter (
      .clk      (clk),
      .reset    (reset),
      .inc      (credit_return[o]),
      .dec      (crd_dec[o]),
      .zero     (crd_zero[o]),
      .overflow (crd_ovf[o])
    );
  end

  // Out-of-range routes are treated as never eligible rather than indexing past the credit array.
  always_comb begin
    eligible = '0;
    body_err = '0;
    for (int unsigned v = 0; v < NUM_VCS; v++) begin
      route[v]    = (state[v] == VC_IDLE) ? vc_outport[v] : route_q[v];
      eligible[v] = reset & vc_valid[v] & (32'(route[v]) < NUM_OUTS) &&
                    !crd_zero[route[v]] && ((state[v] == VC_ACTIVE) || vc_head[v]);
      body_err[v] = vc_valid[v] & (state[v] == VC_IDLE) & ~vc_head[v];
    end
  end

  always_comb begin
    found = 1'b0;
    sel   = '0;
    for (int unsigned k = 0; k < NUM_VCS; k++) begin
      int unsigned idx;
      idx = (32'(rr_ptr) + k) % NUM_VCS;
      if (!found && eligible[idx]) begin
        found = 1'b1;
        sel   = VW'(idx);
      end
    end
    sa_request = '0;
    if (found) sa_request[route[sel]] = 1'b1;
    grant   = |(sa_grant & sa_request);
    stray   = |(sa_grant & ~sa_request);
    crd_dec = grant ? sa_request : '0;
    vc_pop  = '0;
    if (grant) vc_pop[sel] = 1'b1;
  end

  always_comb begin
    for (int unsigned v = 0; v < NUM_VCS; v++) begin
      state_next[v] = state[v];
      route_next[v] = route_q[v];
      if (vc_pop[v]) begin
        if (state[v] == VC_IDLE && vc_head[v] && !vc_tail[v]) begin
          state_next[v] = VC_ACTIVE;
          route_next[v] = vc_outport[v];
        end else if (state[v] == VC_ACTIVE && vc_tail[v]) begin
          state_next[v] = VC_IDLE;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned v = 0; v < NUM_VCS; v++) begin
        state[v]   <= VC_IDLE;
        route_q[v] <= '0;
      end
    end else begin
      for (int unsigned v = 0; v < NUM_VCS; v++) begin
        state[v]   <= state_next[v];
        route_q[v] <= route_next[v];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_ptr       <= '0;
      st_valid     <= 1'b0;
      st_outport   <= '0;
      st_vc        <= '0;
      err_protocol <= 1'b0;
    end else begin
      st_valid     <= grant;
      err_protocol <= err_protocol | (|body_err) | stray | (|crd_ovf);
      if (grant) begin
        rr_ptr     <= (32'(sel) + 1 == NUM_VCS) ? '0 : sel + 1'b1;
        st_outport <= route[sel];
        st_vc      <= sel;
      end
    end
  end

endmodule

// File: tb/tb_sa_input_requester.sv
// Randomized bench for sa_input_requester: packet queues per VC, a downstream credit loop,
// and a queue/arithmetic reference model checked every cycle, plus directed literal scenarios.
module tb_sa_input_requester;
  import router_pkg::*;

  localparam int NV = DEF_NUM_VCS;
  localparam int NO = DEF_NUM_OUTS;
  localparam int CD = DEF_CREDIT_DEPTH;

  logic                     clk = 1'b0;
  logic                     reset;
  logic [NV-1:0]            vc_valid, vc_head, vc_tail;
  logic [NV-1:0][OUT_W-1:0] vc_outport;
  logic [NO-1:0]            credit_return, sa_request, sa_grant;
  logic [NV-1:0]            vc_pop;
  logic                     st_valid;
  logic [OUT_W-1:0]         st_outport;
  logic [VC_W-1:0]          st_vc;
  logic                     err_protocol;

  sa_input_requester #(.NUM_VCS(NV), .NUM_OUTS(NO), .CREDIT_DEPTH(CD)) dut (
    .clk           (clk),
    .reset         (reset),
    .vc_valid      (vc_valid),
    .vc_head       (vc_head),
    .vc_tail       (vc_tail),
    .vc_outport    (vc_outport),
    .credit_return (credit_return),
    .sa_request    (sa_request),
    .sa_grant      (sa_grant),
    .vc_pop        (vc_pop),
    .st_valid      (st_valid),
    .st_outport    (st_outport),
    .st_vc         (st_vc),
    .err_protocol  (err_protocol)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit head;
    bit tail;
    int route;
  } flit_t;

  flit_t fq [NV][$];
  int    pend [NO];

  int    m_credit [NO];
  bit    m_active [NV];
  int    m_lroute [NV];
  int    m_rr;
  bit    m_stv;
  int    m_sto, m_stvc;
  bit    m_err;

  bit [NO-1:0] e_req;
  bit [NV-1:0] e_pop;
  int          e_sel;
  bit          e_gnt;
  int          e_route [NV];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic bit pct(input int p);
    return int'($urandom_range(99)) < p;
  endfunction

  task automatic push_pkt(input int v, input int len, input int route);
    for (int i = 0; i < len; i++) begin
      flit_t f;
      f.head  = (i == 0);
      f.tail  = (i == len - 1);
      f.route = route;
      fq[v].push_back(f);
    end
  endtask

  task automatic model_reset();
    for (int o = 0; o < NO; o++) begin
      m_credit[o] = CD;
      pend[o]     = 0;
    end
    for (int v = 0; v < NV; v++) begin
      m_active[v] = 1'b0;
      m_lroute[v] = 0;
      fq[v].delete();
    end
    m_rr = 0; m_stv = 1'b0; m_sto = 0; m_stvc = 0; m_err = 1'b0;
  endtask

  // Which VC wins: first VC from the round-robin pointer whose front flit can move now.
  task automatic eval_model();
    e_sel = -1;
    e_req = '0;
    for (int v = 0; v < NV; v++)
      e_route[v] = m_active[v] ? m_lroute[v] : int'(vc_outport[v]);
    for (int k = 0; k < NV; k++) begin
      int v;
      v = (m_rr + k) % NV;
      if (e_sel < 0 && vc_valid[v] && m_credit[e_route[v]] > 0 && (m_active[v] || vc_head[v]))
        e_sel = v;
    end
    if (e_sel >= 0) e_req[e_route[e_sel]] = 1'b1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    vc_valid = '0; vc_head = '0; vc_tail = '0; vc_outport = '0;
    credit_return = '0; sa_grant = '0;
    #1;
    chk("rst_sa_request", int'(sa_request), 0);
    chk("rst_vc_pop", int'(vc_pop), 0);
    chk("rst_st_valid", int'(st_valid), 0);
    chk("rst_st_outport", int'(st_outport), 0);
    chk("rst_st_vc", int'(st_vc), 0);
    chk("rst_err", int'(err_protocol), 0);
    model_reset();
    @(posedge clk);
    #1 reset = 1'b1;
  endtask

  // One clock: drive at posedge+1, compare at negedge, advance the model at the next posedge.
  task automatic step(input int vpct, input int gpct, input int rpct,
                      input bit [NO-1:0] xret, input bit [NO-1:0] xgnt);
    bit body;
    for (int v = 0; v < NV; v++) begin
      if (fq[v].size() > 0) begin
        vc_head[v]    = fq[v][0].head;
        vc_tail[v]    = fq[v][0].tail;
        vc_outport[v] = OUT_W'(fq[v][0].route);
        vc_valid[v]   = pct(vpct);
      end else begin
        vc_head[v] = 1'b0; vc_tail[v] = 1'b0; vc_outport[v] = '0; vc_valid[v] = 1'b0;
      end
    end
    for (int o = 0; o < NO; o++)
      credit_return[o] = (pend[o] > 0 && pct(rpct)) | xret[o];
    eval_model();
    sa_grant = pct(gpct) ? e_req : '0;
    sa_grant = sa_grant | xgnt;
    e_gnt = |(sa_grant & e_req);
    e_pop = '0;
    if (e_gnt) e_pop[e_sel] = 1'b1;

    @(negedge clk);
    chk("sa_request", int'(sa_request), int'(e_req));
    chk("vc_pop", int'(vc_pop), int'(e_pop));
    chk("st_valid", int'(st_valid), int'(m_stv));
    chk("st_outport", int'(st_outport), m_sto);
    chk("st_vc", int'(st_vc), m_stvc);
    chk("err_protocol", int'(err_protocol), int'(m_err));

    @(posedge clk);
    body = 1'b0;
    for (int v = 0; v < NV; v++)
      if (vc_valid[v] && !m_active[v] && !vc_head[v]) body = 1'b1;
    if ((sa_grant & ~e_req) != '0 || body) m_err = 1'b1;
    for (int o = 0; o < NO; o++) begin
      bit dec, ret;
      dec = e_gnt && e_route[e_sel] == o;
      ret = credit_return[o];
      if (ret && pend[o] > 0) pend[o]--;
      if (ret && !dec) begin
        if (m_credit[o] == CD) m_err = 1'b1;
        else m_credit[o]++;
      end else if (dec && !ret) begin
        m_credit[o]--;
      end
    end
    if (e_gnt) begin
      flit_t f;
      int o;
      f = fq[e_sel].pop_front();
      o = e_route[e_sel];
      pend[o]++;
      if (f.head && !f.tail) begin
        m_active[e_sel] = 1'b1;
        m_lroute[e_sel] = o;
      end else if (f.tail) begin
        m_active[e_sel] = 1'b0;
      end
      m_rr = (e_sel + 1) % NV;
      m_stv = 1'b1; m_sto = o; m_stvc = e_sel;
    end else begin
      m_stv = 1'b0;
    end
    #1;
  endtask

  task automatic random_run(input int cycles);
    for (int c = 0; c < cycles; c++) begin
      for (int v = 0; v < NV; v++)
        if (fq[v].size() == 0 && pct(30))
          push_pkt(v, int'($urandom_range(1, 3)), int'($urandom_range(0, NO - 1)));
      step(80, 60, 40, '0, '0);
    end
  endtask

  initial begin
    reset = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    do_reset();

    // single-flit packet VC0 -> out2
    push_pkt(0, 1, 2);
    step(100, 100, 0, '0, '0);
    chk("t1_req", int'(e_req), 3'b100);
    chk("t1_pop", int'(e_pop), 4'b0001);
    chk("t1_stv", int'(m_stv), 1);
    chk("t1_sto", m_sto, 2);
    chk("t1_stvc", m_stvc, 0);
    chk("t1_credit2", m_credit[2], 3);
    step(100, 100, 0, '0, '0);

    // three-flit packet VC1 -> out1
    push_pkt(1, 3, 1);
    step(100, 100, 0, '0, '0);
    chk("t2_pop_head", int'(e_pop), 4'b0010);
    chk("t2_active", int'(m_active[1]), 1);
    step(100, 100, 0, '0, '0);
    chk("t2_pop_body", int'(e_pop), 4'b0010);
    step(100, 100, 0, '0, '0);
    chk("t2_pop_tail", int'(e_pop), 4'b0010);
    chk("t2_idle", int'(m_active[1]), 0);
    chk("t2_credit1", m_credit[1], 1);
    step(100, 100, 0, '0, '0);

    // round-robin over all VCs to out0, credit exhaustion and resume
    do_reset();
    for (int v = 0; v < NV; v++) push_pkt(v, 1, 0);
    push_pkt(0, 1, 0);
    for (int i = 0; i < NV; i++) begin
      step(100, 100, 0, '0, '0);
      chk("t3_rr_pop", int'(e_pop), 1 << i);
    end
    chk("t4_credit0", m_credit[0], 0);
    step(100, 100, 0, '0, '0);
    chk("t4_req_masked", int'(e_req), 0);
    step(100, 100, 100, '0, '0);
    chk("t4_req_still_masked", int'(e_req), 0);
    step(100, 100, 0, '0, '0);
    chk("t4_req_resume", int'(e_req), 3'b001);
    chk("t3_wrap_pop", int'(e_pop), 4'b0001);

    // grant withheld
    do_reset();
    push_pkt(1, 1, 0);
    for (int i = 0; i < 3; i++) begin
      step(100, 0, 0, '0, '0);
      chk("t5_req_held", int'(e_req), 3'b001);
      chk("t5_no_pop", int'(e_pop), 0);
      chk("t5_rr_held", m_rr, 0);
    end
    step(100, 100, 0, '0, '0);
    chk("t5_pop", int'(e_pop), 4'b0010);
    chk("t5_rr_adv", m_rr, 2);

    // reset mid-packet
    do_reset();
    push_pkt(0, 1, 1);
    push_pkt(2, 3, 1);
    step(100, 100, 0, '0, '0);
    step(100, 100, 0, '0, '0);
    chk("t6_vc2_active", int'(m_active[2]), 1);
    chk("t6_credit1", m_credit[1], 2);
    do_reset();
    chk("t6_credit1_reset", m_credit[1], CD);
    push_pkt(2, 1, 2);
    step(100, 100, 0, '0, '0);
    chk("t6_vc2_idle_route", int'(e_req), 3'b100);

    // random traffic with an asynchronous reset in the middle
    do_reset();
    random_run(800);
    do_reset();
    random_run(800);
    for (int c = 0; c < 300; c++) step(100, 100, 100, '0, '0);
    for (int o = 0; o < NO; o++) chk("drain_credit", m_credit[o], CD);
    chk("drain_err_clear", int'(m_err), 0);

    // illegal stimulus: credit return at full credit
    step(100, 100, 0, 3'b001, '0);
    chk("t7_ret_full_err", int'(m_err), 1);
    step(100, 100, 0, '0, '0);
    step(100, 100, 0, '0, '0);

    // illegal stimulus: unrequested grant bit
    do_reset();
    step(100, 100, 0, '0, 3'b010);
    chk("t7_stray_err", int'(m_err), 1);
    step(100, 100, 0, '0, '0);

    // illegal stimulus: idle VC fronting a body flit
    do_reset();
    begin
      flit_t f;
      f.head = 1'b0; f.tail = 1'b0; f.route = 1;
      fq[3].push_back(f);
    end
    step(100, 100, 0, '0, '0);
    chk("t7_body_err", int'(m_err), 1);
    chk("t7_body_no_req", int'(e_req), 0);
    fq[3].delete();
    step(100, 100, 0, '0, '0);
    step(100, 100, 0, '0, '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
